mem_tester: RTL and testbench

MEM_TESTER -- requirements
Module: mem_tester

---
 rtl/mem_test_pkg.sv | 31 +++
 rtl/mem_pattern_gen.sv | 56 +++++
 rtl/mem_tester.sv | 190 +++++++++++++++++++
 tb/tb_mem_tester.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_test_pkg.sv
// Shared definitions for the memory tester: FSM states, pattern modes and the
// PRNG (Galois LFSR, taps 32,22,2,1) step used by every pattern generator.
package mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_PRNG = 2'd0,
    MODE_ADDR = 2'd1,
    MODE_INV  = 2'd2,
    MODE_WALK = 2'd3
  } mode_t;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_TAPS) : (s >> 1);
  endfunction

  // An all-zero LFSR would lock up, so a zero seed starts from 1.
  function automatic logic [31:0] lfsr_seed(input logic [31:0] s);
    return (s == 32'd0) ? 32'd1 : s;
  endfunction

endpackage

// File: rtl/mem_pattern_gen.sv
// Data pattern source for one address stream. The PRNG state advances on
// 'next' and restarts from the seed on 'load'; the other modes depend on addr only.
module mem_pattern_gen
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              next,
  input  mode_t             mode,
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] pattern
);

  localparam int AW = (ADDR_W > 32) ? ADDR_W : 32;

  logic [31:0]       lfsr_q;
  logic [DATA_W-1:0] prng_pat;
  logic [AW-1:0]     bit_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
    end else if (load) begin
      lfsr_q <= lfsr_seed(seed);
    end else if (next) begin
      lfsr_q <= lfsr_step(lfsr_q);
    end
  end

  // The 32-bit PRNG word is repeated (or cut) to fill the memory word.
  always_comb begin
    prng_pat = '0;
    for (int i = 0; i < DATA_W; i++) begin
      prng_pat[i] = lfsr_q[i % 32];
    end
  end

  assign bit_idx = AW'(addr) % AW'(DATA_W);

  always_comb begin
    pattern = '0;
    case (mode)
      MODE_PRNG: pattern = prng_pat;
      MODE_ADDR: pattern = DATA_W'(addr);
      MODE_INV:  pattern = ~(DATA_W'(addr));
      MODE_WALK: pattern = DATA_W'(1) << bit_idx;
      default:   pattern = '0;
    endcase
  end

endmodule

// File: rtl/mem_tester.sv
// Memory tester: writes a pattern over [addr_lo, addr_hi], reads it back and
// counts mismatches, repeating for the requested number of passes.
module mem_tester
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = 23,
  parameter int DATA_W = 32,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [31:0]       seed,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  input  logic [7:0]        passes,
  output logic [ADDR_W-1:0] addr,
  output logic              rw,
  output logic [DATA_W-1:0] data_in,
  output logic              in_valid,
  input  logic              busy,
  input  logic              out_valid,
  input  logic [DATA_W-1:0] data_out,
  output logic              running,
  output logic              done,
  output logic              fail,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_syn,
  output logic [7:0]        pass_cnt,
  output logic [7:0]        leds,
  output logic [2:0]        dbg_state
);

  // Handshake: in_valid is raised only while busy is low, so every cycle with
  // in_valid high is an accepted request. out_valid returns one read word per
  // cycle, in request order, with no back-pressure from this block.

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [ADDR_W-1:0] lo_q, hi_q, iss_addr_q, cmp_addr_q;
  logic [7:0]        passes_q, pass_inc;
  logic [31:0]       seed_q, gen_seed;
  logic              cmp_done_q;
  logic              start_ok, to_read, pass_end, last_pass;
  logic              issuing, req_fire, iss_last, cmp_fire, mismatch;
  logic [DATA_W-1:0] iss_pat, cmp_pat, syn;
  logic [6:0]        err_led;

  assign issuing  = (state_q == ST_WRITE) || (state_q == ST_READ);
  assign req_fire = issuing && !busy;
  assign iss_last = (iss_addr_q == hi_q);
  assign in_valid = req_fire;
  assign rw       = req_fire && (state_q == ST_WRITE);
  assign addr     = req_fire ? iss_addr_q : '0;
  assign data_in  = rw ? iss_pat : '0;

  // Comparison runs off the returned data only, so it may overlap issuing reads.
  assign cmp_fire = out_valid && !cmp_done_q &&
                    ((state_q == ST_READ) || (state_q == ST_DRAIN));
  assign syn      = cmp_pat ^ data_out;
  assign mismatch = cmp_fire && (syn != '0);

  assign pass_inc  = (pass_cnt == 8'hFF) ? pass_cnt : pass_cnt + 8'd1;
  assign last_pass = (passes_q != 8'd0) && (pass_inc == passes_q);
  assign gen_seed  = start_ok ? seed : (pass_end ? seed_q + 32'd1 : seed_q);

  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    to_read  = 1'b0;
    pass_end = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            start_ok = 1'b1;
            state_d  = (addr_hi < addr_lo) ? ST_DONE : ST_WRITE;
          end
        end
        ST_WRITE: begin
          if (req_fire && iss_last) begin
            to_read = 1'b1;
            state_d = ST_READ;
          end
        end
        ST_READ: begin
          if (req_fire && iss_last) state_d = ST_DRAIN;
        end
        ST_DRAIN: begin
          if (cmp_done_q) begin
            pass_end = 1'b1;
            state_d  = last_pass ? ST_DONE : ST_WRITE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q         <= MODE_PRNG;
      lo_q           <= '0;
      hi_q           <= '0;
      passes_q       <= '0;
      seed_q         <= '0;
      iss_addr_q     <= '0;
      cmp_addr_q     <= '0;
      cmp_done_q     <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_syn  <= '0;
      pass_cnt       <= '0;
    end else if (start_ok) begin
      mode_q         <= mode_t'(mode);
      lo_q           <= addr_lo;
      hi_q           <= addr_hi;
      passes_q       <= passes;
      seed_q         <= seed;
      iss_addr_q     <= addr_lo;
      cmp_addr_q     <= addr_lo;
      cmp_done_q     <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_syn  <= '0;
      pass_cnt       <= '0;
    end else begin
      // End of range is detected by equality so addr_hi = all-ones never wraps.
      if (req_fire) iss_addr_q <= iss_last ? lo_q : iss_addr_q + ADDR_W'(1);
      if (cmp_fire) begin
        if (cmp_addr_q == hi_q) cmp_done_q <= 1'b1;
        else                    cmp_addr_q <= cmp_addr_q + ADDR_W'(1);
        if (mismatch) begin
          if (err_count != '1) err_count <= err_count + ERR_W'(1);
          if (err_count == '0) begin
            first_err_addr <= cmp_addr_q;
            first_err_syn  <= syn;
          end
        end
      end
      if (pass_end) begin
        pass_cnt   <= pass_inc;
        seed_q     <= seed_q + 32'd1;
        iss_addr_q <= lo_q;
        cmp_addr_q <= lo_q;
        cmp_done_q <= 1'b0;
      end
    end
  end

  mem_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_issue_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok || to_read || pass_end),
    .next    (rw),
    .mode    (mode_q),
    .seed    (gen_seed),
    .addr    (iss_addr_q),
    .pattern (iss_pat)
  );

  mem_pattern_gen #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_cmp_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (start_ok || pass_end),
    .next    (cmp_fire),
    .mode    (mode_q),
    .seed    (gen_seed),
    .addr    (cmp_addr_q),
    .pattern (cmp_pat)
  );

  assign err_led   = (err_count > ERR_W'(127)) ? 7'h7F : err_count[6:0];
  assign leds      = {state_q == ST_READ, err_led};
  assign fail      = (err_count != '0);
  assign done      = (state_q == ST_DONE);
  assign running   = (state_q == ST_WRITE) || (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_tester.sv
// Bench for mem_tester: behavioural memory with fault injection, request
// scoreboard fed from a pass-level reference model, and end-of-test status checks.
module tb_mem_tester;
  import mem_test_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;
  localparam int ERR_W  = 7;

  logic              clk;
  logic              rst_n;
  logic              start, abort;
  logic [1:0]        mode;
  logic [31:0]       seed;
  logic [ADDR_W-1:0] addr_lo, addr_hi;
  logic [7:0]        passes;
  logic [ADDR_W-1:0] addr;
  logic              rw, in_valid;
  logic [DATA_W-1:0] data_in;
  logic              busy, out_valid;
  logic [DATA_W-1:0] data_out;
  logic              running, done, fail;
  logic [ERR_W-1:0]  err_count;
  logic [ADDR_W-1:0] first_err_addr;
  logic [DATA_W-1:0] first_err_syn;
  logic [7:0]        pass_cnt, leds;
  logic [2:0]        dbg_state;

  mem_tester #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ERR_W(ERR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mode(mode), .seed(seed),
    .addr_lo(addr_lo), .addr_hi(addr_hi), .passes(passes),
    .addr(addr), .rw(rw), .data_in(data_in), .in_valid(in_valid),
    .busy(busy), .out_valid(out_valid), .data_out(data_out),
    .running(running), .done(done), .fail(fail), .err_count(err_count),
    .first_err_addr(first_err_addr), .first_err_syn(first_err_syn),
    .pass_cnt(pass_cnt), .leds(leds), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bench state ----------------
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int n_req = 0;
  int last_due = 0;
  int lat_max = 1;
  bit busy_en = 0;
  bit spur_en = 0;
  logic [31:0] stuck_mask = '0;
  logic [31:0] flip_mask  = '0;
  logic [7:0]  flip_addr  = '0;
  logic [31:0] mem [256];

  typedef struct { int due; logic [31:0] data; } resp_t;
  resp_t resp_q[$];
  logic [40:0] exp_q[$];

  int          exp_err, exp_pass;
  logic [7:0]  exp_faddr;
  logic [31:0] exp_fsyn;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] galois(input logic [31:0] s);
    int taps[4] = '{32, 22, 2, 1};
    logic [31:0] m = '0;
    foreach (taps[i]) m[taps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ m) : (s >> 1);
  endfunction

  task automatic plan(input int md, input logic [31:0] sd, input int lo, input int hi, input int np);
    logic [31:0] pat [256];
    logic [31:0] s, rd;
    exp_err = 0; exp_faddr = '0; exp_fsyn = '0;
    exp_pass = (np > 255) ? 255 : np;
    for (int p = 0; p < np; p++) begin
      s = sd + 32'(p);
      if (s == 32'd0) s = 32'd1;
      for (int a = lo; a <= hi; a++) begin
        case (md)
          0: pat[a] = s;
          1: pat[a] = 32'(a);
          2: pat[a] = ~(32'(a));
          default: pat[a] = 32'd1 << (a % 32);
        endcase
        if (md == 0) s = galois(s);
        exp_q.push_back({1'b1, 8'(a), pat[a]});
      end
      for (int a = lo; a <= hi; a++) begin
        exp_q.push_back({1'b0, 8'(a), 32'h0});
        rd = (pat[a] & ~stuck_mask) ^ ((8'(a) == flip_addr) ? flip_mask : 32'h0);
        if (rd != pat[a]) begin
          if (exp_err == 0) begin
            exp_faddr = 8'(a);
            exp_fsyn  = pat[a] ^ rd;
          end
          if (exp_err < 127) exp_err++;
        end
      end
    end
  endtask

  // ---------------- memory driver: busy and read returns ----------------
  initial begin
    busy = 1'b0; out_valid = 1'b0; data_out = '0;
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      busy = busy_en ? 1'($urandom_range(0, 1)) : 1'b0;
      if (resp_q.size() != 0 && resp_q[0].due <= cyc) begin
        out_valid = 1'b1;
        data_out  = resp_q[0].data;
        void'(resp_q.pop_front());
      end else if (spur_en && $urandom_range(0, 3) == 0 &&
                   (dbg_state == ST_WRITE || dbg_state == ST_IDLE || dbg_state == ST_DONE)) begin
        out_valid = 1'b1;
        data_out  = $urandom;
      end else begin
        out_valid = 1'b0;
        data_out  = $urandom;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int due;
    forever begin
      @(negedge clk);
      if (in_valid === 1'b1) begin
        n_req++;
        if (rw) begin
          mem[addr] = data_in & ~stuck_mask;
        end else begin
          due = cyc + int'($urandom_range(1, lat_max));
          if (due <= last_due) due = last_due + 1;
          last_due = due;
          resp_q.push_back('{due, mem[addr] ^ ((addr == flip_addr) ? flip_mask : 32'h0)});
        end
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_req: got rw=%0d addr=%0h data=%0h, expected no request",
                   rw, addr, data_in);
        end else begin
          chk("req", {23'h0, rw, addr, data_in}, {23'h0, exp_q.pop_front()});
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run(input int md, input logic [31:0] sd, input int lo, input int hi,
                     input int np, input int plan_np);
    plan(md, sd, lo, hi, plan_np);
    mode = 2'(md); seed = sd; addr_lo = 8'(lo); addr_hi = 8'(hi); passes = 8'(np);
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input string t, input int budget);
    bit ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, expected 1", t, budget);
    end
  endtask

  task automatic check_end(input string t);
    chk({t, "_done"}, done, 1);
    chk({t, "_running"}, running, 0);
    chk({t, "_err_count"}, err_count, exp_err);
    chk({t, "_fail"}, fail, (exp_err != 0));
    chk({t, "_first_err_addr"}, first_err_addr, exp_faddr);
    chk({t, "_first_err_syn"}, first_err_syn, exp_fsyn);
    chk({t, "_pass_cnt"}, pass_cnt, exp_pass);
    chk({t, "_leds"}, leds, exp_err);
    chk({t, "_exp_left"}, exp_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; seed = '0;
    addr_lo = '0; addr_hi = '0; passes = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_valid", in_valid, 0);
    chk("rst_rw", rw, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_leds", leds, 0);
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_done", done, 0);
    chk("rst_running", running, 0);
    chk("rst_fail", fail, 0);
    chk("rst_err_count", err_count, 0);
    chk("rst_pass_cnt", pass_cnt, 0);
    rst_n = 1'b1;

    // Ideal memory, PRNG, full range up to the all-ones address.
    run(0, $urandom, 0, 255, 1, 1);
    @(negedge clk);
    chk("t1_running", running, 1);
    chk("t1_done_early", done, 0);
    wait_done("t1", 3000);
    check_end("t1");

    // Single flipped bit at 0x42, address pattern.
    flip_addr = 8'h42; flip_mask = 32'h8; lat_max = 3;
    run(1, 0, 0, 255, 1, 1);
    wait_done("t2", 3000);
    check_end("t2");
    chk("t2_leds_const", leds, 8'h01);
    flip_mask = '0;

    // Back-pressure, variable latency, walking-one, three passes; a start
    // pulse mid-run with other settings must be ignored.
    busy_en = 1; lat_max = 8; spur_en = 1;
    run(3, $urandom, 0, 255, 3, 3);
    repeat (60) @(posedge clk);
    #1 mode = 2'd0; addr_hi = 8'h03; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("t3", 12000);
    check_end("t3");
    spur_en = 0;

    // PRNG over two passes; the second pass seed wraps to 0 and becomes 1.
    run(0, 32'hFFFF_FFFF, 'h10, 'h2F, 2, 2);
    wait_done("t3b", 2000);
    check_end("t3b");

    // Stuck-at-0 on bit 0 with inverted address: 128 misses saturate at 127.
    busy_en = 0; lat_max = 2; stuck_mask = 32'h1;
    run(2, 0, 0, 255, 1, 1);
    wait_done("t4", 3000);
    check_end("t4");
    chk("t4_leds_sat", leds, 8'h7F);
    stuck_mask = '0;

    // Empty range: no requests, done within two cycles of start.
    run(1, 0, 'h10, 'h0F, 1, 0);
    @(posedge clk);
    @(negedge clk);
    check_end("t5");

    // Endless run aborted three writes into the third pass.
    busy_en = 1; lat_max = 4; n_req = 0;
    run(0, $urandom, 'h20, 'h27, 0, 3);
    for (int i = 0; i < 2000 && n_req < 35; i++) @(posedge clk);
    chk("t6_reached", n_req, 35);
    #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    exp_q.delete();
    resp_q.delete();
    @(negedge clk);
    chk("t6_in_valid", in_valid, 0);
    chk("t6_state", dbg_state, ST_IDLE);
    chk("t6_running", running, 0);
    chk("t6_pass_cnt", pass_cnt, 2);
    repeat (3) @(posedge clk);

    // Asynchronous reset while reads are in flight.
    busy_en = 0;
    run(1, 0, 0, 255, 1, 1);
    for (int i = 0; i < 2000 && dbg_state != ST_READ; i++) @(negedge clk);
    chk("t7_in_read", dbg_state, ST_READ);
    repeat (5) @(posedge clk);
    #2;
    exp_q.delete();
    rst_n = 1'b0;
    #1;
    chk("t7_in_valid", in_valid, 0);
    chk("t7_addr", addr, 0);
    chk("t7_rw", rw, 0);
    chk("t7_leds", leds, 0);
    chk("t7_state", dbg_state, ST_IDLE);
    chk("t7_running", running, 0);
    chk("t7_pass_cnt", pass_cnt, 0);
    resp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    @(negedge clk);
    chk("t7_idle_after", dbg_state, ST_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
